// File: rtl/paddle_ctrl_pkg.sv
// Shared constants, AI state encoding and position helpers for the paddle controller.
//  - Screen geometry (V_DISP, SLDE_W, BODY_L, BALL_W) and derived rows CTR, YMIN, YMAX.
//  - ai_state_e: AI_IDLE=0, AI_TRACK=1, AI_RETURN=2.
//  - clamp_y / move_y: signed 12-bit clamp of a row into [YMIN, YMAX] and one button step.
package paddle_ctrl_pkg;

    localparam int V_DISP = 480;
    localparam int SLDE_W = 10;
    localparam int BODY_L = 80;
    localparam int BALL_W = 16;

    localparam logic [9:0] CTR  = 10'((V_DISP - BODY_L) / 2);
    localparam logic [9:0] YMIN = 10'(SLDE_W);
    localparam logic [9:0] YMAX = 10'(V_DISP - SLDE_W - BODY_L);

    localparam logic signed [11:0] YMIN_S  = 12'(SLDE_W);
    localparam logic signed [11:0] YMAX_S  = 12'(V_DISP - SLDE_W - BODY_L);
    // Offset from ball top row to the paddle top that centres the paddle on the ball.
    localparam logic signed [11:0] TGT_OFS = 12'(BALL_W / 2 - BODY_L / 2);

    // Debounced button index order inside the controller.
    localparam int B_UP0 = 0;
    localparam int B_DN0 = 1;
    localparam int B_UP1 = 2;
    localparam int B_DN1 = 3;

    typedef enum logic [1:0] {
        AI_IDLE   = 2'd0,
        AI_TRACK  = 2'd1,
        AI_RETURN = 2'd2
    } ai_state_e;

    function automatic logic [9:0] clamp_y(input logic signed [11:0] v);
        if (v < YMIN_S)      return YMIN;
        else if (v > YMAX_S) return YMAX;
        else                 return v[9:0];
    endfunction

    // One button-driven move; both or neither pressed holds the row.
    function automatic logic [9:0] move_y(input logic [9:0] y, input logic up,
                                          input logic dn, input logic [9:0] stp);
        logic signed [11:0] t;
        t = $signed({2'b00, y});
        if (up && !dn)      t = t - $signed({2'b00, stp});
        else if (dn && !up) t = t + $signed({2'b00, stp});
        return clamp_y(t);
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Game-side signal bundle of the paddle controller.
//  master: ball engine / board side, drives game controls, buttons and ball position.
//  slave : paddle_ctrl, drives the two paddle rows and the AI debug state.
interface paddle_ctrl_if;

    logic       start;
    logic       s;
    logic       guiwei;
    logic       ai_en;
    logic       btn_up0;
    logic       btn_dn0;
    logic       btn_up1;
    logic       btn_dn1;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] padbody_y0;
    logic [9:0] padbody_y1;
    logic [1:0] ai_state;

    modport master (
        output start, s, guiwei, ai_en,
        output btn_up0, btn_dn0, btn_up1, btn_dn1,
        output ball_x, ball_y,
        input  padbody_y0, padbody_y1, ai_state
    );

    modport slave (
        input  start, s, guiwei, ai_en,
        input  btn_up0, btn_dn0, btn_up1, btn_dn1,
        input  ball_x, ball_y,
        output padbody_y0, padbody_y1, ai_state
    );

endinterface

// File: rtl/paddle_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stability counter.
//  vga_clk, sys_rst_n : clock, async active-low reset
//  btn_in             : raw asynchronous button level
//  btn_out            : debounced level, moves DEB_CNT clocks after the synced level settles
module btn_debounce #(
    parameter int DEB_CNT = 500000
) (
    input  logic vga_clk,
    input  logic sys_rst_n,
    input  logic btn_in,
    output logic btn_out
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Any clock where the synced level agrees with the output restarts the count.
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEB_CNT - 1)) deb_d = sync2_q;
            else                           cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_out = deb_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle controller: two paddle top rows for the ball engine.
//  vga_clk, sys_rst_n : pixel clock, async active-low reset
//  pif (slave)        : start/s/guiwei/ai_en, four raw buttons, ball_x/ball_y in;
//                       padbody_y0 (left), padbody_y1 (right), ai_state out (all registered)
// Left paddle follows its buttons; right paddle follows its buttons or, with ai_en,
// the AI tracker. Moves happen only on the move tick from the speed divider.
module paddle_ctrl import paddle_ctrl_pkg::*; #(
    parameter int STEP     = 2,
    parameter int DIV_FAST = 80000,
    parameter int DIV_SLOW = 180000,
    parameter int DEB_CNT  = 500000,
    parameter int AI_DEAD  = 4
) (
    input  logic          vga_clk,
    input  logic          sys_rst_n,
    paddle_ctrl_if.slave  pif
);

    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int DW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [9:0]         STEP10 = 10'(STEP);
    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic signed [11:0] DEAD_S = 12'(AI_DEAD);

    // ---------------- buttons ----------------
    logic [3:0] btn_raw, btn_deb;
    assign btn_raw = {pif.btn_dn1, pif.btn_up1, pif.btn_dn0, pif.btn_up0};

    for (genvar i = 0; i < 4; i++) begin : g_deb
        btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .vga_clk   (vga_clk),
            .sys_rst_n (sys_rst_n),
            .btn_in    (btn_raw[i]),
            .btn_out   (btn_deb[i])
        );
    end

    // ---------------- move tick ----------------
    logic [DW-1:0] div_cnt_q, div_cnt_d, div_last;
    logic          tick;

    assign div_last = pif.s ? DW'(DIV_FAST - 1) : DW'(DIV_SLOW - 1);
    assign tick     = (div_cnt_q == div_last);
    // ">=" also catches a count stranded above the new limit after s switches: wrap, no tick.
    assign div_cnt_d = (div_cnt_q >= div_last) ? '0 : div_cnt_q + DW'(1);

    // ---------------- AI helpers ----------------
    logic [9:0]         x_prev_q, x_prev_d;
    logic               approaching;
    logic signed [11:0] tgt_raw, d_tgt, d_ctr;
    logic [9:0]         tgt;

    assign approaching = (pif.ball_x > x_prev_q);
    assign tgt_raw     = $signed({2'b00, pif.ball_y}) + TGT_OFS;
    assign tgt         = clamp_y(tgt_raw);

    // ---------------- paddles + AI FSM ----------------
    logic [9:0] y0_q, y0_d, y1_q, y1_d;
    ai_state_e  st_q, st_d;

    assign d_tgt = $signed({2'b00, tgt}) - $signed({2'b00, y1_q});
    assign d_ctr = $signed({2'b00, CTR}) - $signed({2'b00, y1_q});

    always_comb begin
        y0_d     = y0_q;
        y1_d     = y1_q;
        st_d     = st_q;
        x_prev_d = tick ? pif.ball_x : x_prev_q;

        if (!pif.start) begin
            y0_d = CTR;
            y1_d = CTR;
            st_d = AI_IDLE;
        end else if (pif.guiwei) begin
            // Point scored: recentre even if a tick lands on the same clock.
            y0_d = CTR;
            y1_d = CTR;
            st_d = pif.ai_en ? AI_RETURN : AI_IDLE;
        end else begin
            if (tick) y0_d = move_y(y0_q, btn_deb[B_UP0], btn_deb[B_DN0], STEP10);

            if (!pif.ai_en) begin
                st_d = AI_IDLE;
                if (tick) y1_d = move_y(y1_q, btn_deb[B_UP1], btn_deb[B_DN1], STEP10);
            end else begin
                case (st_q)
                    AI_IDLE: st_d = AI_TRACK;
                    AI_TRACK: if (tick) begin
                        if (d_tgt > DEAD_S)       y1_d = y1_q + STEP10;
                        else if (d_tgt < -DEAD_S) y1_d = y1_q - STEP10;
                        if (!approaching) st_d = AI_RETURN;
                    end
                    AI_RETURN: if (tick) begin
                        // Residual under one step is left alone rather than overshooting.
                        if (d_ctr >= STEP_S)       y1_d = y1_q + STEP10;
                        else if (d_ctr <= -STEP_S) y1_d = y1_q - STEP10;
                        if (approaching) st_d = AI_TRACK;
                    end
                    default: st_d = AI_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt_q <= '0;
            x_prev_q  <= '0;
            y0_q      <= CTR;
            y1_q      <= CTR;
            st_q      <= AI_IDLE;
        end else begin
            div_cnt_q <= div_cnt_d;
            x_prev_q  <= x_prev_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            st_q      <= st_d;
        end
    end

    assign pif.padbody_y0 = y0_q;
    assign pif.padbody_y1 = y1_q;
    assign pif.ai_state   = st_q;

endmodule
